// File: rtl/dealer_motor_ctrl.sv
// dealer_motor_ctrl
// ----------------------------------------------------------------------------
// Dealing sequencer for the poker dealer turntable. On start it latches the
// player count, then alternates between feeding one card (WAIT) and rotating
// the turntable one sector to the next seat (ROTATE). After the final card it
// rotates one more sector back to the home seat (REMAIN), returns to idle
// (RESET) and pulses done.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        one-cycle deal request, accepted only while idle
//   stop         one-cycle abort, returns to idle from any busy state
//   players[3:0] player count (2..4, anything else deals as 2 players)
//   motor_state  00 RESET, 01 ROTATE, 10 WAIT, 11 REMAIN
//   phase[3:0]   one-hot stepper coil drive, 0000 while idle
//   feed_en      card feeder motor enable
//   seat[1:0]    seat currently facing the feeder (0 = home)
//   cards_dealt  cards fed in the current or last deal
//   busy         high whenever motor_state != RESET
//   done         one-cycle pulse on the first idle cycle after a full deal
// All outputs are registered.
// ----------------------------------------------------------------------------
module dealer_motor_ctrl #(
  parameter int STEP_DIV         = 250000,
  parameter int STEPS_PER_REV    = 48,
  parameter int CARDS_PER_PLAYER = 5,
  parameter int FEED_CYCLES      = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] players,
  output logic [1:0] motor_state,
  output logic [3:0] phase,
  output logic       feed_en,
  output logic [1:0] seat,
  output logic [5:0] cards_dealt,
  output logic       busy,
  output logic       done
);

  localparam int DW = $clog2(STEP_DIV);
  localparam int SW = $clog2(STEPS_PER_REV / 2 + 1);
  localparam int FW = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE   = DW'(STEP_DIV - 2);
  localparam logic [FW-1:0] FEED_LAST = FW'(FEED_CYCLES - 1);

  // Sector lengths and card targets per player count, selected by a mux.
  localparam logic [SW-1:0] SEC2 = SW'(STEPS_PER_REV / 2);
  localparam logic [SW-1:0] SEC3 = SW'(STEPS_PER_REV / 3);
  localparam logic [SW-1:0] SEC4 = SW'(STEPS_PER_REV / 4);
  localparam logic [5:0]    TGT2 = 6'(2 * CARDS_PER_PLAYER);
  localparam logic [5:0]    TGT3 = 6'(3 * CARDS_PER_PLAYER);
  localparam logic [5:0]    TGT4 = 6'(4 * CARDS_PER_PLAYER);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_ROTATE = 2'b01,
    ST_WAIT   = 2'b10,
    ST_REMAIN = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    np_q, np_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [5:0]    tgt_q, tgt_d;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] step_q, step_d;
  logic [FW-1:0] feed_cnt_q, feed_cnt_d;
  logic [1:0]    seat_q, seat_d;
  logic [5:0]    cards_q, cards_d;
  logic [3:0]    phase_q, phase_d;
  logic          feed_en_q, feed_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    np_d       = np_q;
    sec_d      = sec_q;
    tgt_d      = tgt_q;
    idx_d      = idx_q;
    div_d      = div_q;
    step_d     = step_q;
    feed_cnt_d = feed_cnt_q;
    seat_d     = seat_q;
    cards_d    = cards_q;
    done_d     = 1'b0;

    case (state_q)
      ST_RESET: begin
        // stop has priority over a coincident start.
        if (start && !stop) begin
          case (players)
            4'd3: begin
              np_d  = 3'd3;
              sec_d = SEC3;
              tgt_d = TGT3;
            end
            4'd4: begin
              np_d  = 3'd4;
              sec_d = SEC4;
              tgt_d = TGT4;
            end
            default: begin
              np_d  = 3'd2;
              sec_d = SEC2;
              tgt_d = TGT2;
            end
          endcase
          cards_d    = 6'd0;
          seat_d     = 2'd0;
          feed_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (stop) begin
          state_d = ST_RESET;
        end else if (feed_cnt_q == FEED_LAST) begin
          cards_d    = cards_q + 6'd1;
          feed_cnt_d = '0;
          div_d      = '0;
          step_d     = '0;
          state_d    = ((cards_q + 6'd1) == tgt_q) ? ST_REMAIN : ST_ROTATE;
        end else begin
          feed_cnt_d = feed_cnt_q + 1'b1;
        end
      end

      default: begin // ST_ROTATE, ST_REMAIN share the stepping logic
        if (stop) begin
          state_d = ST_RESET;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          // The index loads one cycle ahead of terminal count so the coils
          // switch on the terminal-count cycle itself; the final step of a
          // sector therefore lands inside the rotating state, never alongside
          // feed_en.
          if (div_q == DIV_PRE) begin
            idx_d  = idx_q + 2'd1;
            step_d = step_q + 1'b1;
          end
          if (div_q == DIV_LAST && step_q == sec_q) begin
            seat_d  = (({1'b0, seat_q} + 3'd1) == np_q) ? 2'd0 : seat_q + 2'd1;
            if (state_q == ST_REMAIN) begin
              state_d = ST_RESET;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
    endcase

    // Output registers follow the next state so they line up with it.
    phase_d   = (state_d == ST_RESET) ? 4'b0000 : (4'b0001 << idx_d);
    feed_en_d = (state_d == ST_WAIT);
    busy_d    = (state_d != ST_RESET);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      np_q       <= 3'd0;
      sec_q      <= '0;
      tgt_q      <= 6'd0;
      idx_q      <= 2'd0;
      div_q      <= '0;
      step_q     <= '0;
      feed_cnt_q <= '0;
      seat_q     <= 2'd0;
      cards_q    <= 6'd0;
      phase_q    <= 4'b0000;
      feed_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      np_q       <= np_d;
      sec_q      <= sec_d;
      tgt_q      <= tgt_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      step_q     <= step_d;
      feed_cnt_q <= feed_cnt_d;
      seat_q     <= seat_d;
      cards_q    <= cards_d;
      phase_q    <= phase_d;
      feed_en_q  <= feed_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign motor_state = state_q;
  assign phase       = phase_q;
  assign feed_en     = feed_en_q;
  assign seat        = seat_q;
  assign cards_dealt = cards_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dealer_motor_ctrl.sv
// Testbench for dealer_motor_ctrl. A reference model expands each deal into
// the expected per-cycle output trace (cards, sectors, steps), which is then
// compared cycle by cycle; aborts and resets truncate the trace.
module tb_dealer_motor_ctrl;

  localparam int SD  = 4;
  localparam int SPR = 12;
  localparam int CPP = 2;
  localparam int FC  = 3;

  localparam logic [1:0] M_RESET  = 2'b00;
  localparam logic [1:0] M_ROTATE = 2'b01;
  localparam logic [1:0] M_WAIT   = 2'b10;
  localparam logic [1:0] M_REMAIN = 2'b11;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] players;
  logic [1:0] motor_state;
  logic [3:0] phase;
  logic       feed_en;
  logic [1:0] seat;
  logic [5:0] cards_dealt;
  logic       busy;
  logic       done;

  dealer_motor_ctrl #(
    .STEP_DIV(SD),
    .STEPS_PER_REV(SPR),
    .CARDS_PER_PLAYER(CPP),
    .FEED_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .players(players),
    .motor_state(motor_state),
    .phase(phase),
    .feed_en(feed_en),
    .seat(seat),
    .cards_dealt(cards_dealt),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] ph;
    logic       fe;
    logic [1:0] seat;
    logic [5:0] cards;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   exp_idx[$];
  int   checks;
  int   failures;
  int   m_idx;
  int   m_seat;
  int   m_cards;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st    = motor_state;
    o.ph    = phase;
    o.fe    = feed_en;
    o.seat  = seat;
    o.cards = cards_dealt;
    o.busy  = busy;
    o.done  = done;
    return o;
  endfunction

  function automatic obs_t mk(input logic [1:0] st, input int idx, input bit fe,
                              input int s, input int c, input bit b, input bit d);
    obs_t o;
    logic [3:0] one;
    one     = 4'b0001;
    o.st    = st;
    o.ph    = (st == M_RESET) ? 4'b0000 : (one << idx);
    o.fe    = fe;
    o.seat  = 2'(s);
    o.cards = 6'(c);
    o.busy  = b;
    o.done  = d;
    return o;
  endfunction

  // Expected trace of one full deal starting with the first WAIT cycle.
  task automatic build_trace(input int np);
    int n, sec, s, idx;
    logic [1:0] rs;
    exp_q.delete();
    exp_idx.delete();
    n   = np * CPP;
    sec = SPR / np;
    s   = 0;
    idx = m_idx;
    for (int c = 0; c < n; c++) begin
      for (int f = 0; f < FC; f++) begin
        exp_q.push_back(mk(M_WAIT, idx, 1'b1, s, c, 1'b1, 1'b0));
        exp_idx.push_back(idx);
      end
      rs = (c + 1 == n) ? M_REMAIN : M_ROTATE;
      for (int k = 1; k <= sec * SD; k++) begin
        if (k % SD == 0) idx = (idx + 1) % 4;
        exp_q.push_back(mk(rs, idx, 1'b0, s, c + 1, 1'b1, 1'b0));
        exp_idx.push_back(idx);
      end
      s = (s + 1 == np) ? 0 : s + 1;
    end
    exp_q.push_back(mk(M_RESET, 0, 1'b0, s, n, 1'b0, 1'b1));
    exp_idx.push_back(idx);
    exp_q.push_back(mk(M_RESET, 0, 1'b0, s, n, 1'b0, 1'b0));
    exp_idx.push_back(idx);
  endtask

  // stop_at/rst_at: trace index after which to abort (-1 none, -2 random stop).
  task automatic run_deal(input logic [3:0] p, input int stop_at_in, input int rst_at,
                          input bit junk, input string name);
    int np, stop_at, sz, ndone, busy_cyc;
    bit aborted;
    string how;
    np = (p >= 4'd2 && p <= 4'd4) ? int'(p) : 2;
    build_trace(np);
    sz = exp_q.size();
    stop_at = stop_at_in;
    if (stop_at == -2)
      stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, sz - 3)) : -1;
    aborted  = 1'b0;
    ndone    = 0;
    busy_cyc = 0;
    how      = "complete";
    @(negedge clk);
    start   = 1'b1;
    players = p;
    for (int j = 0; j < sz; j++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check($sformatf("%s[%0d]", name, j), 32'(sample()), 32'(exp_q[j]));
      if (done) ndone++;
      if (busy) busy_cyc++;
      if (j == stop_at) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check($sformatf("%s_stop", name), 32'(sample()),
              32'(mk(M_RESET, 0, 1'b0, exp_q[j].seat, exp_q[j].cards, 1'b0, 1'b0)));
        m_idx   = exp_idx[j];
        m_seat  = exp_q[j].seat;
        m_cards = exp_q[j].cards;
        aborted = 1'b1;
        how     = $sformatf("stopped@%0d", j);
        break;
      end
      if (j == rst_at) begin
        #2 rst = 1'b1;
        #1 check($sformatf("%s_rst_async", name), 32'(sample()), 32'd0);
        @(negedge clk);
        check($sformatf("%s_rst_hold", name), 32'(sample()), 32'd0);
        rst     = 1'b0;
        m_idx   = 0;
        m_seat  = 0;
        m_cards = 0;
        aborted = 1'b1;
        how     = $sformatf("reset@%0d", j);
        break;
      end
      if (junk && exp_q[j].busy) begin
        start   = ($urandom_range(0, 3) == 0);
        players = 4'($urandom_range(0, 15));
      end
    end
    if (!aborted) begin
      m_idx   = exp_idx[sz - 1];
      m_seat  = exp_q[sz - 1].seat;
      m_cards = np * CPP;
      check($sformatf("%s_done_count", name), 32'(ndone), 32'd1);
      check($sformatf("%s_busy_cycles", name), 32'(busy_cyc), 32'(sz - 2));
    end
    start = 1'b0;
    stop  = 1'b0;
    $display("deal %s players=%0d np=%0d %s cards=%0d seat=%0d phase_idx=%0d",
             name, p, np, how, m_cards, m_seat, m_idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    m_idx    = 0;
    m_seat   = 0;
    m_cards  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    players  = 4'd2;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(sample()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle", 32'(sample()), 32'd0);

    run_deal(4'd2, -1, -1, 1'b0, "np2");
    run_deal(4'd4, -1, -1, 1'b0, "np4");
    // np=3: trace 0-2 WAIT, 3-18 ROTATE, 19-21 WAIT, 22-37 ROTATE; abort in the 2nd ROTATE.
    run_deal(4'd3, 28, -1, 1'b0, "np3_stop");
    run_deal(4'd3, -1, -1, 1'b0, "np3");
    run_deal(4'd7, -1, -1, 1'b1, "np7_junk");

    // start and stop together while idle: stays idle, nothing cleared.
    @(negedge clk);
    start   = 1'b1;
    stop    = 1'b1;
    players = 4'd4;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", 32'(sample()), 32'(mk(M_RESET, 0, 1'b0, m_seat, m_cards, 1'b0, 1'b0)));
    @(negedge clk);
    check("start_stop_idle2", 32'(sample()), 32'(mk(M_RESET, 0, 1'b0, m_seat, m_cards, 1'b0, 1'b0)));
    $display("deal start_stop_same_cycle stays idle cards=%0d seat=%0d", m_cards, m_seat);

    // Reset partway through the first ROTATE, then a deal from phase index 0.
    run_deal(4'd4, -1, 9, 1'b0, "rst_mid");
    run_deal(4'd3, -1, -1, 1'b0, "after_rst");

    for (int r = 0; r < 8; r++)
      run_deal(4'($urandom_range(0, 15)), -2, -1, 1'b1, $sformatf("rand%0d", r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
